// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : pipeline_hazard_ctrl                                        |
// | Description : Central sequencer for the five pipeline registers (PC,      |
// |               IF/ID, ID/EX, EX/MEM, MEM/WB). Produces write enables and   |
// |               synchronous flushes from data-memory wait, multi-cycle MDU  |
// |               ops, branch redirect and load-use hazards. All outputs are  |
// |               combinational from inputs and internal state.               |
// | Option      : `define PIPE_CTRL_PERF_EN to build the stall/flush perf     |
// |               counters; otherwise stall_cnt/flush_cnt are constant zero.  |
// | Ports       : clk, rst (async, active-high)                               |
// |               id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID source operands  |
// |               ex_mem_read/ex_rd/ex_is_mdu/ex_redirect : EX stage status   |
// |               mem_req/mem_ready : MEM stage data-memory handshake         |
// |               *_we, *_flush : pipeline register controls                  |
// |               mdu_busy : EX held by a multi-cycle op (not final cycle)    |
// |               stall_cnt/flush_cnt : perf counters                         |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_mdu,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             idex_we,
   output logic             exmem_we,
   output logic             memwb_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             mdu_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Counter must be at least one bit wide even when MDU_LAT=1 (no wait state used).
   localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
   localparam logic [CW-1:0] c_mdu_reload = CW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);
   localparam bit c_mdu_multi = (MDU_LAT > 1);

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MDU_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   mdu_cnt_q, mdu_cnt_d;

   logic mem_stall;
   logic mdu_start;
   logic mdu_hold;
   logic load_use;
   logic redirect_act;
   logic load_use_act;

   always_comb begin
      mem_stall = mem_req & ~mem_ready;
      mdu_start = (state_q == ST_RUN) & ex_is_mdu & c_mdu_multi;
      // Under a memory stall EX is frozen by the MEM_STALL controls, so the
      // MDU hold does not apply (and its counter does not advance).
      mdu_hold  = ~mem_stall &
                  (mdu_start | ((state_q == ST_MDU_WAIT) & (mdu_cnt_q != '0)));
      load_use  = ex_mem_read & (ex_rd != 5'd0) &
                  ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                   (id_uses_rs2 & (id_rs2 == ex_rd)));
      redirect_act = ~mem_stall & ~mdu_hold & ex_redirect;
      load_use_act = ~mem_stall & ~mdu_hold & ~ex_redirect & load_use;
   end

   // Next-state: everything freezes while the data memory is stalling.
   always_comb begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
      if (!mem_stall) begin
         if (mdu_start) begin
            state_d   = ST_MDU_WAIT;
            mdu_cnt_d = c_mdu_reload;
         end else if (state_q == ST_MDU_WAIT) begin
            if (mdu_cnt_q != '0) begin
               mdu_cnt_d = mdu_cnt_q - 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         mdu_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mdu_cnt_q <= mdu_cnt_d;
      end
   end

   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      mdu_busy    = 1'b0;
      if (mem_stall) begin
         // Hold everything up to EX/MEM; push a bubble into WB.
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_flush = 1'b1;
      end else if (mdu_hold) begin
         // Keep the MDU op in EX, send a bubble down to MEM.
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_flush = 1'b1;
         mdu_busy    = 1'b1;
      end else if (redirect_act) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (load_use_act) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_flush  = 1'b1;
      end
      if (rst) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_we    = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         exmem_flush = 1'b0;
         memwb_flush = 1'b0;
         mdu_busy    = 1'b0;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(~pc_we);
      flush_cnt_d = flush_cnt_q + CNT_W'(redirect_act);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

   // EX holds a non-branch instruction while waiting on the MDU.
   a_no_redirect_in_mdu_wait : assert property (
      @(posedge clk) disable iff (rst)
      !((state_q == ST_MDU_WAIT) && ex_redirect)
   ) else $error("ex_redirect asserted during MDU_WAIT");

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_pipeline_hazard_ctrl                                     |
// | Description : Directed, table-driven bench for pipeline_hazard_ctrl       |
// |               (MDU_LAT=4). Optional PIPE_CTRL_PERF_EN changes the         |
// |               expected counter values.                                    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_is_mdu, ex_redirect;
   logic             mem_req, mem_ready;
   logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic             ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_is_mdu(ex_is_mdu), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
      .exmem_we(exmem_we), .memwb_we(memwb_we),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,exmem,memwb}_flush, mdu_busy
   logic [9:0] outs;
   assign outs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, mdu_busy};

   localparam logic [9:0] E_ZERO = 10'b00000_0000_0;
   localparam logic [9:0] E_DEF  = 10'b11111_0000_0;
   localparam logic [9:0] E_LU   = 10'b00111_0100_0;
   localparam logic [9:0] E_RED  = 10'b11111_1100_0;
   localparam logic [9:0] E_MEM  = 10'b00001_0001_0;
   localparam logic [9:0] E_HOLD = 10'b00011_0010_1;

`ifdef PIPE_CTRL_PERF_EN
   localparam int EXP_STALL = 4;
   localparam int EXP_FLUSH = 1;
`else
   localparam int EXP_STALL = 0;
   localparam int EXP_FLUSH = 0;
`endif

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       mr;
      logic [4:0] rd;
      logic       mdu;
      logic       redir;
      logic       req;
      logic       rdy;
      logic [9:0] exp;
   } vec_t;

   int n_err    = 0;
   int n_checks = 0;

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic mdu,
                               input logic redir, input logic req,
                               input logic rdy, input logic [9:0] exp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
      v.mdu = mdu; v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
      ex_mem_read = v.mr; ex_rd = v.rd; ex_is_mdu = v.mdu;
      ex_redirect = v.redir; mem_req = v.req; mem_ready = v.rdy;
   endtask

   task automatic idle();
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF));
   endtask

   task automatic chk(input logic [9:0] exp, input string nm);
      n_checks++;
      if (outs !== exp) begin
         n_err++;
         $display("FAIL %s: outputs got %b expected %b", nm, outs, exp);
      end
   endtask

   task automatic chk_cnt(input int exp_s, input int exp_f, input string nm);
      n_checks++;
      if (stall_cnt !== CNT_W'(exp_s) || flush_cnt !== CNT_W'(exp_f)) begin
         n_err++;
         $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d expected %0d/%0d",
                  nm, stall_cnt, flush_cnt, exp_s, exp_f);
      end
   endtask

   // Inputs already driven just after a negedge: check 1ns later, then
   // advance through the posedge to the next negedge.
   task automatic step(input logic [9:0] exp, input string nm);
      #1;
      chk(exp, nm);
      @(negedge clk);
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = mk(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
      vecs[1]  = mk(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
      vecs[2]  = mk(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
      vecs[3]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
      vecs[4]  = mk(5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, E_LU);
      vecs[5]  = mk(5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, E_RED);
      vecs[6]  = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_MEM);
      vecs[7]  = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_DEF);
      vecs[8]  = mk(5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, E_MEM);
      vecs[9]  = mk(5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF);
      vecs[10] = mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_MEM);

      // Reset state
      rst = 1'b1;
      idle();
      @(negedge clk);
      #1;
      chk(E_ZERO, "reset_outputs");
      chk_cnt(0, 0, "reset_counters");
      @(negedge clk);
      rst = 1'b0;
      step(E_DEF, "idle_after_reset");

      // Load x5 in EX, ID reads rs2=x5: one bubble, then the load has moved on
      apply(mk(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU));
      step(E_LU, "load_use_stall");
      idle();
      step(E_DEF, "load_use_release");

      // Redirect together with a load-use
      apply(mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, E_RED));
      step(E_RED, "redirect_over_load_use");

      // MDU_LAT=4: three hold cycles, fourth advances
      idle();
      ex_is_mdu = 1'b1;
      for (int i = 0; i < 3; i++) step(E_HOLD, $sformatf("mdu_hold_%0d", i));
      step(E_DEF, "mdu_final");
      idle();
      step(E_DEF, "mdu_back_to_run");

      chk_cnt(EXP_STALL, EXP_FLUSH, "perf_counters");

      // Combinational table (state stays RUN throughout)
      for (int i = 0; i < 11; i++) begin
         apply(vecs[i]);
         step(vecs[i].exp, $sformatf("vec_%0d", i));
      end

      // Memory stall in the middle of MDU_WAIT: residency becomes 4+3
      idle();
      ex_is_mdu = 1'b1;
      step(E_HOLD, "mdu_ms_hold_0");
      step(E_HOLD, "mdu_ms_hold_1");
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step(E_MEM, $sformatf("mdu_ms_memstall_%0d", i));
      mem_req = 1'b0;
      step(E_HOLD, "mdu_ms_hold_2");
      step(E_DEF, "mdu_ms_final");
      idle();
      step(E_DEF, "mdu_ms_run");

      // Reset in the middle of MDU_WAIT
      ex_is_mdu = 1'b1;
      step(E_HOLD, "mdu_pre_reset_0");
      step(E_HOLD, "mdu_pre_reset_1");
      rst = 1'b1;
      #1;
      chk(E_ZERO, "mid_mdu_reset_outputs");
      chk_cnt(0, 0, "mid_mdu_reset_counters");
      @(negedge clk);
      rst = 1'b0;
      idle();
      step(E_DEF, "after_reset_run");
      // A fresh MDU op gets its full three hold cycles again
      ex_is_mdu = 1'b1;
      for (int i = 0; i < 3; i++) step(E_HOLD, $sformatf("mdu_fresh_hold_%0d", i));
      step(E_DEF, "mdu_fresh_final");
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
